// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
// The master drives operation launch and HI/LO writes; the slave reports status and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO: WIDTH shift-add or restoring steps plus a sign fix.
// Optional MULDIV_DIVZERO_EN: divide by zero short-circuits to a one-cycle done with div_zero set.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DZERO} state_t;

  state_t           state, state_nxt;
  logic             busy;
  logic [CW-1:0]    cnt;
  logic             is_div, is_sgn, sign_q, sign_r;
  logic [WIDTH-1:0] mag_b, acc_hi, acc_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_q;
`endif

  // Operands are reduced to magnitudes at launch; signs are restored in FIX.
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sgn_op = ~bus.op[0];
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;

  // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_lt;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, mag_b & {WIDTH{acc_lo[0]}}};
    div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    div_lt  = div_sh < {1'b0, mag_b};
    div_sub = div_sh[WIDTH-1:0] - mag_b;
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = div_lt ? div_sh[WIDTH-1:0] : div_sub;
      step_lo = {acc_lo[WIDTH-2:0], ~div_lt};
    end
  end

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    if (is_sgn) begin
      if (is_div) begin
        if (sign_q) fix_lo = -acc_lo;
        if (sign_r) fix_hi = -acc_hi;
      end else if (sign_q) begin
        {fix_hi, fix_lo} = prod_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_nxt = CALC;
`ifdef MULDIV_DIVZERO_EN
          if (bus.op[1] && bus.b == '0) state_nxt = DZERO;
`endif
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          // Direct writes land now; a simultaneous start overwrites them at FIX.
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div <= bus.op[1];
            is_sgn <= sgn_op;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            mag_b  <= b_mag;
            acc_hi <= '0;
            acc_lo <= a_mag;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          cnt    <= '0;
        end
        default: begin
          done_q <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
          dz_q   <= 1'b1;
`endif
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif
endmodule
